ex_mem_stage: RTL and testbench

EX/MEM pipeline boundary of the pipelined RISC-V core. The block registers the ALU result and its carry/zero/overflow/sign flags alongside store data and MEM/WB control, and resolves conditional branches and jumps from the registered flags in the MEM stage. It drives a one-shot redirect to fetch and squashes the wrong-path instruction arriving from EX. It also keeps retired-branch and taken-branch counters.

---
 rtl/ex_mem_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// ex_mem_stage : EX/MEM pipeline register with MEM-stage branch resolution,
//                one-shot fetch redirect, wrong-path squash, branch counters.
// Rev 1.0
// ============================================================================
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_r,
  input  logic        ex_cf,
  input  logic        ex_zf,
  input  logic        ex_vf,
  input  logic        ex_sf,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_target,
  input  logic [31:0] ex_pc4,
  input  logic [31:0] ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_wb_sel,
  input  logic        stall,
  input  logic        flush,
  output logic        mem_valid,
  output logic [31:0] mem_r,
  output logic [31:0] mem_pc4,
  output logic [31:0] mem_rs2,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic [1:0]  mem_wb_sel,
  output logic        mem_taken,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count
);

  logic        valid_q, valid_d;
  logic [31:0] r_q, r_d;
  logic        cf_q, cf_d, zf_q, zf_d, vf_q, vf_d, sf_q, sf_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_branch_q, is_branch_d;
  logic        is_jump_q, is_jump_d;
  logic [31:0] target_q, target_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic        redirect_done_q, redirect_done_d;
  logic        squash_pending_q, squash_pending_d;
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] br_taken_q, br_taken_d;

  logic cond;
  logic kill;

  // Branch condition evaluated on flags of a-b, carry meaning "no borrow".
  always_comb begin
    cond = 1'b0;
    case (funct3_q)
      3'b000:  cond = zf_q;
      3'b001:  cond = ~zf_q;
      3'b100:  cond = sf_q ^ vf_q;
      3'b101:  cond = ~(sf_q ^ vf_q);
      3'b110:  cond = ~cf_q;
      3'b111:  cond = cf_q;
      default: cond = 1'b0;
    endcase
  end

  assign mem_taken = valid_q & (is_jump_q | (is_branch_q & cond));
  assign redirect  = mem_taken & ~redirect_done_q;
  assign kill      = redirect | squash_pending_q;

  always_comb begin
    valid_d          = valid_q;
    r_d              = r_q;
    cf_d             = cf_q;
    zf_d             = zf_q;
    vf_d             = vf_q;
    sf_d             = sf_q;
    funct3_d         = funct3_q;
    is_branch_d      = is_branch_q;
    is_jump_d        = is_jump_q;
    target_d         = target_q;
    pc4_d            = pc4_q;
    rs2_d            = rs2_q;
    rd_d             = rd_q;
    reg_write_d      = reg_write_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    wb_sel_d         = wb_sel_q;
    redirect_done_d  = redirect_done_q;
    squash_pending_d = squash_pending_q;
    br_count_d       = br_count_q;
    br_taken_d       = br_taken_q;

    if (flush) begin
      valid_d          = 1'b0;
      is_branch_d      = 1'b0;
      is_jump_d        = 1'b0;
      reg_write_d      = 1'b0;
      mem_read_d       = 1'b0;
      mem_write_d      = 1'b0;
      wb_sel_d         = 2'b00;
      redirect_done_d  = 1'b0;
      squash_pending_d = 1'b0;
    end else if (stall) begin
      // Remember the redirect so it is not repeated and the wrong-path EX
      // instruction is still discarded once the stall releases.
      if (redirect) begin
        redirect_done_d  = 1'b1;
        squash_pending_d = 1'b1;
      end
    end else begin
      if (valid_q) begin
        br_count_d = br_count_q + {31'b0, is_branch_q};
        br_taken_d = br_taken_q + {31'b0, is_branch_q & cond};
      end
      if (kill) begin
        valid_d          = 1'b0;
        is_branch_d      = 1'b0;
        is_jump_d        = 1'b0;
        reg_write_d      = 1'b0;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        wb_sel_d         = 2'b00;
        redirect_done_d  = 1'b0;
        squash_pending_d = 1'b0;
      end else begin
        valid_d         = ex_valid;
        r_d             = ex_r;
        cf_d            = ex_cf;
        zf_d            = ex_zf;
        vf_d            = ex_vf;
        sf_d            = ex_sf;
        funct3_d        = ex_funct3;
        is_branch_d     = ex_is_branch;
        is_jump_d       = ex_is_jump;
        target_d        = ex_target;
        pc4_d           = ex_pc4;
        rs2_d           = ex_rs2;
        rd_d            = ex_rd;
        reg_write_d     = ex_reg_write;
        mem_read_d      = ex_mem_read;
        mem_write_d     = ex_mem_write;
        wb_sel_d        = ex_wb_sel;
        redirect_done_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q          <= 1'b0;
      r_q              <= 32'h0;
      cf_q             <= 1'b0;
      zf_q             <= 1'b0;
      vf_q             <= 1'b0;
      sf_q             <= 1'b0;
      funct3_q         <= 3'b000;
      is_branch_q      <= 1'b0;
      is_jump_q        <= 1'b0;
      target_q         <= 32'h0;
      pc4_q            <= 32'h0;
      rs2_q            <= 32'h0;
      rd_q             <= 5'd0;
      reg_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      wb_sel_q         <= 2'b00;
      redirect_done_q  <= 1'b0;
      squash_pending_q <= 1'b0;
      br_count_q       <= 32'h0;
      br_taken_q       <= 32'h0;
    end else begin
      valid_q          <= valid_d;
      r_q              <= r_d;
      cf_q             <= cf_d;
      zf_q             <= zf_d;
      vf_q             <= vf_d;
      sf_q             <= sf_d;
      funct3_q         <= funct3_d;
      is_branch_q      <= is_branch_d;
      is_jump_q        <= is_jump_d;
      target_q         <= target_d;
      pc4_q            <= pc4_d;
      rs2_q            <= rs2_d;
      rd_q             <= rd_d;
      reg_write_q      <= reg_write_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      wb_sel_q         <= wb_sel_d;
      redirect_done_q  <= redirect_done_d;
      squash_pending_q <= squash_pending_d;
      br_count_q       <= br_count_d;
      br_taken_q       <= br_taken_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_r          = r_q;
  assign mem_pc4        = pc4_q;
  assign mem_rs2        = rs2_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_wb_sel     = wb_sel_q;
  assign redirect_pc    = target_q;
  assign br_count       = br_count_q;
  assign br_taken_count = br_taken_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_ex_mem_stage : directed self-checking bench for ex_mem_stage.
// Rev 1.0
// ============================================================================
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_r;
  logic        ex_cf, ex_zf, ex_vf, ex_sf;
  logic [2:0]  ex_funct3;
  logic        ex_is_branch, ex_is_jump;
  logic [31:0] ex_target, ex_pc4, ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [1:0]  ex_wb_sel;
  logic        stall, flush;
  logic        mem_valid;
  logic [31:0] mem_r, mem_pc4, mem_rs2;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write;
  logic [1:0]  mem_wb_sel;
  logic        mem_taken, redirect;
  logic [31:0] redirect_pc, br_count, br_taken_count;

  int n_tests = 0;
  int n_fail  = 0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_r(ex_r),
    .ex_cf(ex_cf), .ex_zf(ex_zf), .ex_vf(ex_vf), .ex_sf(ex_sf),
    .ex_funct3(ex_funct3), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_target(ex_target), .ex_pc4(ex_pc4), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_wb_sel(ex_wb_sel),
    .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_r(mem_r), .mem_pc4(mem_pc4), .mem_rs2(mem_rs2),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_wb_sel(mem_wb_sel),
    .mem_taken(mem_taken), .redirect(redirect), .redirect_pc(redirect_pc),
    .br_count(br_count), .br_taken_count(br_taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_r = 32'h0; ex_cf = 1'b0; ex_zf = 1'b0; ex_vf = 1'b0;
    ex_sf = 1'b0; ex_funct3 = 3'b000; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    ex_target = 32'h0; ex_pc4 = 32'h0; ex_rs2 = 32'h0; ex_rd = 5'd0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_wb_sel = 2'b00;
  endtask

  // Drive a conditional branch whose flags come from a-b (carry = no borrow).
  task automatic drive_branch(input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] tgt);
    logic [32:0] s;
    clear_ex();
    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
    ex_valid     = 1'b1;
    ex_is_branch = 1'b1;
    ex_funct3    = f3;
    ex_target    = tgt;
    ex_r         = s[31:0];
    ex_cf        = s[32];
    ex_zf        = (s[31:0] == 32'h0);
    ex_sf        = s[31];
    ex_vf        = (a[31] != b[31]) && (s[31] != a[31]);
  endtask

  task automatic run_branch(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic exp_taken);
    drive_branch(f3, a, b, 32'h40);
    step();
    chk({tag, "_taken"}, {31'b0, mem_taken}, {31'b0, exp_taken});
    clear_ex();
    step();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    clear_ex();
    ex_valid = 1'b1; ex_r = $urandom; ex_rd = 5'($urandom); ex_is_jump = 1'b1;
    ex_reg_write = 1'b1; ex_mem_write = 1'b1; ex_target = $urandom;
    step(); step();
    chk("rst_valid", {31'b0, mem_valid}, 32'h0);
    chk("rst_r", mem_r, 32'h0);
    chk("rst_rd", {27'b0, mem_rd}, 32'h0);
    chk("rst_taken", {31'b0, mem_taken}, 32'h0);
    chk("rst_redirect", {31'b0, redirect}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_br_count", br_count, 32'h0);
    chk("rst_br_taken", br_taken_count, 32'h0);

    // First instruction after reset release
    rst = 1'b1;
    clear_ex();
    ex_valid = 1'b1; ex_r = 32'h1234; ex_rd = 5'd5; ex_reg_write = 1'b1;
    step();
    chk("first_r", mem_r, 32'h1234);
    chk("first_rd", {27'b0, mem_rd}, 32'd5);
    chk("first_valid", {31'b0, mem_valid}, 32'h1);
    chk("first_regwr", {31'b0, mem_reg_write}, 32'h1);
    chk("first_taken", {31'b0, mem_taken}, 32'h0);
    chk("first_redirect", {31'b0, redirect}, 32'h0);

    run_branch("beq", 3'b000, 32'd7, 32'd7, 1'b1);
    run_branch("blt", 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1);
    run_branch("bltu", 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_branch("bgeu", 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1);
    run_branch("f3_010", 3'b010, 32'd3, 32'd3, 1'b0);
    run_branch("bge", 3'b101, 32'd1, 32'hFFFF_FFFF, 1'b1);
    chk("cond_br_count", br_count, 32'd6);
    chk("cond_br_taken", br_taken_count, 32'd4);

    // Taken BEQ followed by a wrong-path ADD
    drive_branch(3'b000, 32'd3, 32'd3, 32'h100);
    step();
    chk("beq_redirect", {31'b0, redirect}, 32'h1);
    chk("beq_redirect_pc", redirect_pc, 32'h100);
    clear_ex();
    ex_valid = 1'b1; ex_reg_write = 1'b1; ex_r = 32'hAAAA; ex_rd = 5'd7;
    step();
    chk("add_squashed", {31'b0, mem_valid}, 32'h0);
    chk("add_redirect_off", {31'b0, redirect}, 32'h0);
    chk("add_regwr", {31'b0, mem_reg_write}, 32'h0);
    chk("beq_br_count", br_count, 32'd7);
    chk("beq_br_taken", br_taken_count, 32'd5);
    clear_ex();
    step();

    // Taken BNE with a 3-cycle stall starting in the redirect cycle
    drive_branch(3'b001, 32'd5, 32'd6, 32'h200);
    step();
    chk("bne_redirect", {31'b0, redirect}, 32'h1);
    chk("bne_redirect_pc", redirect_pc, 32'h200);
    stall = 1'b1;
    clear_ex();
    ex_valid = 1'b1; ex_reg_write = 1'b1; ex_r = 32'hBAD; ex_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_redirect_off", {31'b0, redirect}, 32'h0);
      chk("stall_hold_valid", {31'b0, mem_valid}, 32'h1);
      chk("stall_hold_taken", {31'b0, mem_taken}, 32'h1);
    end
    chk("stall_br_count", br_count, 32'd7);
    stall = 1'b0;
    step();
    chk("post_stall_bubble", {31'b0, mem_valid}, 32'h0);
    chk("post_stall_rd", {31'b0, mem_reg_write}, 32'h0);
    chk("bne_br_count", br_count, 32'd8);
    chk("bne_br_taken", br_taken_count, 32'd6);
    clear_ex();
    ex_valid = 1'b1; ex_reg_write = 1'b1; ex_r = 32'h5555; ex_rd = 5'd3;
    step();
    chk("next_valid", {31'b0, mem_valid}, 32'h1);
    chk("next_r", mem_r, 32'h5555);
    chk("next_rd", {27'b0, mem_rd}, 32'd3);

    // Flush together with stall while EX holds a store
    clear_ex();
    ex_valid = 1'b1; ex_mem_write = 1'b1; ex_rs2 = 32'hDEAD;
    stall = 1'b1; flush = 1'b1;
    step();
    chk("flush_valid", {31'b0, mem_valid}, 32'h0);
    chk("flush_memwr", {31'b0, mem_mem_write}, 32'h0);
    chk("flush_regwr", {31'b0, mem_reg_write}, 32'h0);
    stall = 1'b0; flush = 1'b0;
    step();
    chk("store_memwr", {31'b0, mem_mem_write}, 32'h1);
    chk("store_rs2", mem_rs2, 32'hDEAD);
    chk("store_valid", {31'b0, mem_valid}, 32'h1);

    // Flush in the redirect cycle: redirect still shown, bubble loads
    drive_branch(3'b000, 32'd9, 32'd9, 32'h300);
    step();
    chk("fr_redirect", {31'b0, redirect}, 32'h1);
    flush = 1'b1;
    clear_ex();
    ex_valid = 1'b1; ex_reg_write = 1'b1;
    step();
    flush = 1'b0;
    chk("fr_valid", {31'b0, mem_valid}, 32'h0);
    chk("fr_redirect_off", {31'b0, redirect}, 32'h0);
    chk("fr_br_count", br_count, 32'd8);

    // Reset in the middle of a stalled redirect
    drive_branch(3'b000, 32'd1, 32'd1, 32'h400);
    step();
    stall = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, mem_valid}, 32'h0);
    chk("midrst_redirect", {31'b0, redirect}, 32'h0);
    chk("midrst_br_count", br_count, 32'h0);
    chk("midrst_br_taken", br_taken_count, 32'h0);
    step();
    rst = 1'b1; stall = 1'b0;
    clear_ex();
    ex_valid = 1'b1; ex_r = 32'h77; ex_rd = 5'd1;
    step();
    chk("after_rst_redirect", {31'b0, redirect}, 32'h0);
    chk("after_rst_capture", {31'b0, mem_valid}, 32'h1);
    chk("after_rst_r", mem_r, 32'h77);

    // Counter wrap: preload all-ones, retire one branch
    drive_branch(3'b010, 32'd1, 32'd2, 32'h0);
    step();
    force dut.br_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_count_q;
    clear_ex();
    step();
    chk("wrap_br_count", br_count, 32'h0);
    chk("wrap_br_taken", br_taken_count, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
